countdown_timer: RTL

Countdown companion to the stopwatch in the multimodal clock. It loads an HH:MM:SS preset as BCD digits and decrements it once per second, deriving the second from the 1 kHz system tick. It asserts an expiry flag and pulse at 00:00:00. Its digit outputs use the same BCD digit layout as the stopwatch, so the display path can select between the two sources.

---
 rtl/countdown_timer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// HH:MM:SS BCD countdown timer for the multimodal clock. Decrements once per
// TICKS_PER_SEC system ticks and flags expiry at 00:00:00.
module countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 1000
) (
  input  logic       clock_1kHz,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] set_h1,
  input  logic [3:0] set_h0,
  input  logic [3:0] set_m1,
  input  logic [3:0] set_m0,
  input  logic [3:0] set_s1,
  input  logic [3:0] set_s0,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       running,
  output logic       expired,
  output logic       expired_pulse,
  output logic       load_err
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic [3:0]    h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0]    h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
  logic          exp_pulse_q, exp_pulse_d;
  logic          load_err_q, load_err_d;

  logic [3:0] nh1, nh0, nm1, nm0, ns1, ns0;
  logic       b_s0, b_s1, b_m0, b_m1, b_h0;
  logic       preset_ok, time_zero, dec_zero;

  assign preset_ok = (set_s0 <= 4'd9) && (set_s1 <= 4'd5) &&
                     (set_m0 <= 4'd9) && (set_m1 <= 4'd5) &&
                     (set_h1 <= 4'd2) && (set_h0 <= 4'd9) &&
                     !((set_h1 == 4'd2) && (set_h0 > 4'd3));

  assign time_zero = ({h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} == '0);

  // One-second BCD borrow chain, seconds units first.
  always_comb begin
    ns0 = s0_q - 4'd1;
    b_s0 = 1'b0;
    if (s0_q == 4'd0) begin
      ns0 = 4'd9;
      b_s0 = 1'b1;
    end
    ns1 = s1_q;
    b_s1 = 1'b0;
    if (b_s0) begin
      if (s1_q == 4'd0) begin
        ns1 = 4'd5;
        b_s1 = 1'b1;
      end else begin
        ns1 = s1_q - 4'd1;
      end
    end
    nm0 = m0_q;
    b_m0 = 1'b0;
    if (b_s1) begin
      if (m0_q == 4'd0) begin
        nm0 = 4'd9;
        b_m0 = 1'b1;
      end else begin
        nm0 = m0_q - 4'd1;
      end
    end
    nm1 = m1_q;
    b_m1 = 1'b0;
    if (b_m0) begin
      if (m1_q == 4'd0) begin
        nm1 = 4'd5;
        b_m1 = 1'b1;
      end else begin
        nm1 = m1_q - 4'd1;
      end
    end
    nh0 = h0_q;
    b_h0 = 1'b0;
    if (b_m1) begin
      if (h0_q == 4'd0) begin
        nh0 = 4'd9;
        b_h0 = 1'b1;
      end else begin
        nh0 = h0_q - 4'd1;
      end
    end
    nh1 = h1_q;
    if (b_h0) nh1 = h1_q - 4'd1;
    dec_zero = ({nh1, nh0, nm1, nm0, ns1, ns0} == '0);
  end

  always_comb begin
    state_d     = state_q;
    prescale_d  = prescale_q;
    h1_d        = h1_q;
    h0_d        = h0_q;
    m1_d        = m1_q;
    m0_d        = m0_q;
    s1_d        = s1_q;
    s0_d        = s0_q;
    exp_pulse_d = 1'b0;
    load_err_d  = 1'b0;
    if (load) begin
      if (preset_ok) begin
        {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} =
          {set_h1, set_h0, set_m1, set_m0, set_s1, set_s0};
        prescale_d = '0;
        state_d    = S_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (pause) begin
      // A pause on the wrap cycle leaves the prescaler at LAST, so the
      // pending decrement lands on the first RUN edge after resume.
      if (state_q == S_RUN) state_d = S_PAUSED;
    end else if (start && (state_q == S_IDLE || state_q == S_PAUSED)) begin
      if (!time_zero) state_d = S_RUN;
    end else if (state_q == S_RUN && !time_zero) begin
      if (prescale_q == LAST) begin
        prescale_d = '0;
        {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} = {nh1, nh0, nm1, nm0, ns1, ns0};
        if (dec_zero) begin
          state_d     = S_EXPIRED;
          exp_pulse_d = 1'b1;
        end
      end else begin
        prescale_d = prescale_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_1kHz or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prescale_q  <= '0;
      h1_q        <= '0;
      h0_q        <= '0;
      m1_q        <= '0;
      m0_q        <= '0;
      s1_q        <= '0;
      s0_q        <= '0;
      exp_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescale_q  <= prescale_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      exp_pulse_q <= exp_pulse_d;
      load_err_q  <= load_err_d;
    end
  end

  assign {h1, h0, m1, m0, s1, s0} = {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q};
  assign running       = (state_q == S_RUN);
  assign expired       = (state_q == S_EXPIRED);
  assign expired_pulse = exp_pulse_q;
  assign load_err      = load_err_q;

endmodule
